// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit and receive paths.
//   - FRAME_W      : line frame length in bit times (start + data + parity/stop)
//   - frame_mode_e : {eight,pen} encoding, identical on both paths
//   - tx_state_e   : transmit framer states
//   - calc_parity  : even/odd parity over 7 or 8 data bits
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int FRAME_W = 11;

    typedef enum logic [1:0] {
        MODE_7N = 2'b00,  // 7 data bits, no parity
        MODE_7P = 2'b01,  // 7 data bits, parity
        MODE_8N = 2'b10,  // 8 data bits, no parity
        MODE_8P = 2'b11   // 8 data bits, parity
    } frame_mode_e;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_e;

    // ohel = 0 gives even parity (plain XOR), ohel = 1 gives odd parity.
    // Bit 7 only takes part when eight = 1.
    function automatic logic calc_parity(
        input logic [7:0] data,
        input logic       eight,
        input logic       ohel
    );
        logic p;
        p = eight ? ^data : ^data[6:0];
        return p ^ ohel;
    endfunction

endpackage

// File: rtl/tx_frame_builder.sv
// ---------------------------------------------------------------------------
// tx_frame_builder
//   Purely combinational: turns a data byte plus the line configuration into
//   the 11-bit line frame, bit 0 transmitted first. Positions not used by
//   data or parity are mark (1) and act as stop bits.
//
// Ports
//   eight   in  1 : 1 = 8 data bits, 0 = 7 data bits (data_in[7] ignored)
//   pen     in  1 : parity enable
//   ohel    in  1 : parity sense, 0 = even, 1 = odd
//   data_in in  8 : byte to frame
//   frame   out 11: line frame, frame[0] is the start bit
// ---------------------------------------------------------------------------
module tx_frame_builder
    import uart_pkg::*;
(
    input  logic               eight,
    input  logic               pen,
    input  logic               ohel,
    input  logic [7:0]         data_in,
    output logic [FRAME_W-1:0] frame
);

    frame_mode_e mode;
    logic        parity;

    assign mode   = frame_mode_e'({eight, pen});
    assign parity = calc_parity(data_in, eight, ohel);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case can leave it unassigned and infer a latch.
        frame    = '1;
        frame[0] = 1'b0;
        case (mode)
            MODE_7N: frame[7:1] = data_in[6:0];
            MODE_7P: begin
                frame[7:1] = data_in[6:0];
                frame[8]   = parity;
            end
            MODE_8N: frame[8:1] = data_in;
            MODE_8P: begin
                frame[8:1] = data_in;
                frame[9]   = parity;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
//   UART transmit path. On an accepted load the byte is framed (start, 7/8
//   data bits, optional parity, stop bits padding to 11 bit times) and
//   shifted out LSB-first, each bit held for max(baud_k,1) clocks.
//
// Parameters
//   BAUD_W        : width of the bit-time count
//
// Ports
//   clk     in  1      : clock, rising edge
//   rst_n   in  1      : asynchronous active-low reset
//   eight   in  1      : 1 = 8 data bits, 0 = 7 data bits
//   pen     in  1      : parity enable
//   ohel    in  1      : parity sense, 0 = even, 1 = odd
//   baud_k  in  BAUD_W : clocks per bit, 0 behaves as 1
//   load    in  1      : start strobe, honoured only while txrdy = 1
//   data_in in  8      : byte to send
//   tx      out 1      : serial line, idle high
//   txrdy   out 1      : idle and ready for load
// ---------------------------------------------------------------------------
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int BAUD_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BAUD_W-1:0] baud_k,
    input  logic              load,
    input  logic [7:0]        data_in,
    output logic              tx,
    output logic              txrdy
);

    tx_state_e          state;
    tx_state_e          state_next;

    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] shift_reg;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [BAUD_W-1:0]  baud_max;      // latched terminal count, max(baud_k,1)-1
    logic [BAUD_W-1:0]  baud_max_in;
    logic [3:0]         bit_cnt;

    logic               accept;
    logic               bit_done;
    logic               last_bit;

    tx_frame_builder u_builder (
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .data_in (data_in),
        .frame   (frame)
    );

    // baud_k = 0 folds onto baud_k = 1: terminal count 0, one clock per bit.
    assign baud_max_in = (baud_k == '0) ? '0 : baud_k - BAUD_W'(1);

    assign accept   = (state == TX_IDLE) && load;
    assign bit_done = (state == TX_SHIFT) && (baud_cnt == baud_max);
    assign last_bit = bit_done && (bit_cnt == 4'(FRAME_W - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:  if (load)     state_next = TX_SHIFT;
            TX_SHIFT: if (last_bit) state_next = TX_IDLE;
            default:                state_next = TX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, bit-time counter, bit counter.
    // The shift register idles at all ones and refills with ones while
    // shifting, so tx can come straight from bit 0 in every state: it is
    // mark while idle and back to mark once all 11 bits have left.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '1;
            baud_cnt  <= '0;
            baud_max  <= '0;
            bit_cnt   <= '0;
        end else if (accept) begin
            shift_reg <= frame;
            baud_cnt  <= '0;
            baud_max  <= baud_max_in;
            bit_cnt   <= '0;
        end else if (state == TX_SHIFT) begin
            if (bit_done) begin
                shift_reg <= {1'b1, shift_reg[FRAME_W-1:1]};
                bit_cnt   <= bit_cnt + 4'd1;
                baud_cnt  <= '0;
            end else begin
                baud_cnt  <= baud_cnt + BAUD_W'(1);
            end
        end
    end

    // Both outputs come directly from flops; no input reaches them
    // combinationally.
    assign tx    = shift_reg[0];
    assign txrdy = (state == TX_IDLE);

endmodule
